// File: rtl/golay24_dec_metric_sel.sv
`default_nettype none
// ============================================================================
//  Module   : golay24_dec_metric_sel
//  Purpose  : Frame-wise maximum-metric candidate selector for the golay24
//             soft decoder. Tracks the best (codeword, metric, index) over a
//             sop/val/eop framed candidate stream and emits it as a one-cycle
//             result pulse after the eop candidate.
//  Revision : 1.0 - initial release
// ============================================================================
module golay24_dec_metric_sel #(
    parameter int pLLR_W = 4,
    parameter int pIDX_W = 5
) (
    input  logic                     iclk,
    input  logic                     ireset,
    input  logic                     iclkena,
    input  logic                     isop,
    input  logic                     ival,
    input  logic                     ieop,
    input  logic [23:0]              idat,
    input  logic signed [pLLR_W+4:0] imetric,
    output logic                     oval,
    output logic [23:0]              odat,
    output logic signed [pLLR_W+4:0] ometric,
    output logic [pIDX_W-1:0]        oidx,
    output logic [pIDX_W-1:0]        ocnt,
    output logic                     oerr
);

    // Metric width matches metric_t (signed, pLLR_W+5 bits); codeword is dat_t.
    localparam int c_METRIC_W = pLLR_W + 5;
    localparam int c_DAT_W    = 24;

    localparam logic [pIDX_W-1:0] c_CNT_MAX = {pIDX_W{1'b1}};
    localparam logic [pIDX_W-1:0] c_CNT_ONE = {{(pIDX_W-1){1'b0}}, 1'b1};
    localparam logic [pIDX_W-1:0] c_IDX_ZERO = '0;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_ACC  = 1'b1;

    logic [0:0]                   r_state;
    logic [c_DAT_W-1:0]           r_best_dat;
    logic signed [c_METRIC_W-1:0] r_best_metric;
    logic [pIDX_W-1:0]            r_best_idx;
    logic [pIDX_W-1:0]            r_cnt;

    logic                         w_greater;
    logic [pIDX_W-1:0]            w_cnt_next;
    logic [c_DAT_W-1:0]           w_sel_dat;
    logic signed [c_METRIC_W-1:0] w_sel_metric;
    logic [pIDX_W-1:0]            w_sel_idx;

    // Running-best update for a continuation candidate: strictly greater wins,
    // so ties keep the earlier candidate. The index of the incoming candidate
    // is the current (saturated) count.
    always_comb begin
        w_greater    = imetric > r_best_metric;
        w_cnt_next   = (r_cnt == c_CNT_MAX) ? r_cnt : (r_cnt + c_CNT_ONE);
        w_sel_dat    = w_greater ? idat    : r_best_dat;
        w_sel_metric = w_greater ? imetric : r_best_metric;
        w_sel_idx    = w_greater ? r_cnt   : r_best_idx;
    end

    // Frame tracking, best-candidate registers and result/error pulses.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            r_state       <= c_ST_IDLE;
            r_best_dat    <= '0;
            r_best_metric <= '0;
            r_best_idx    <= '0;
            r_cnt         <= '0;
            oval          <= 1'b0;
            oerr          <= 1'b0;
            odat          <= '0;
            ometric       <= '0;
            oidx          <= '0;
            ocnt          <= '0;
        end else if (iclkena) begin
            oval <= 1'b0;
            oerr <= 1'b0;
            if (ival) begin
                if (isop) begin
                    // A sop inside an open frame abandons it; the new
                    // candidate always opens a fresh frame.
                    oerr          <= (r_state == c_ST_ACC);
                    r_best_dat    <= idat;
                    r_best_metric <= imetric;
                    r_best_idx    <= c_IDX_ZERO;
                    r_cnt         <= c_CNT_ONE;
                    if (ieop) begin
                        oval    <= 1'b1;
                        odat    <= idat;
                        ometric <= imetric;
                        oidx    <= c_IDX_ZERO;
                        ocnt    <= c_CNT_ONE;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_state <= c_ST_ACC;
                    end
                end else if (r_state == c_ST_ACC) begin
                    r_best_dat    <= w_sel_dat;
                    r_best_metric <= w_sel_metric;
                    r_best_idx    <= w_sel_idx;
                    r_cnt         <= w_cnt_next;
                    if (ieop) begin
                        oval    <= 1'b1;
                        odat    <= w_sel_dat;
                        ometric <= w_sel_metric;
                        oidx    <= w_sel_idx;
                        ocnt    <= w_cnt_next;
                        r_state <= c_ST_IDLE;
                    end
                end
                // Candidates without sop while idle are dropped silently.
            end
        end
    end

endmodule
`default_nettype wire
